// File: rtl/host_packet_pkg.sv
// Shared types and constants for the host packet transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package host_packet_pkg;

    // Serializer states: waiting for a word, or streaming its bytes out.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Position of the byte currently presented on the link (0 = MSB).
    typedef logic [1:0] byte_idx_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int FIRST_BYTE_MSB = 31;

    localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/host_packet_tx_sync_word_fifo.sv
// Single-clock word FIFO with first-word-fall-through read data.
// Latency: a word written at edge N is readable (empty=0) after N.
// Backpressure: writes dropped while the registered full flag is set.
module sync_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_wr;
    logic             do_rd;

    // Full is a register, so a write at a full edge is rejected even if a pop
    // frees a slot on the same edge; empty comes from the registered count,
    // so a freshly written word is never poppable on its own write edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Next occupancy from the accepted write and pop of this cycle.
    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers (wrap naturally, DEPTH is a power of two), count and full flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
        end
    end

endmodule

// File: rtl/host_packet_tx.sv
// Buffers 32-bit result packets and serializes them MSB-first onto a byte link.
// Latency: word written at edge N is popped at N+1, first byte valid after N+2.
// Backpressure: tx_ready=0 freezes the byte; full FIFO rejects writes (sticky overflow).
module host_packet_tx
    import host_packet_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic [31:0]      hostPacketFIFOWrite_packet,
    input  logic             hostPacketFIFOWriteEn,
    output logic             hostPacketFIFOWrite_full,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] wordsSent
);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_SEND = 1'(SEND);

    logic [31:0]            fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop;

    logic [0:0]             state;
    logic                   primed;
    logic [31:0]            shreg;
    byte_idx_t              idx;
    logic                   byte_done;
    logic                   last_byte;

    sync_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk100),
        .rst   (rst),
        .wr_en (hostPacketFIFOWriteEn),
        .rd_en (pop),
        .din   (hostPacketFIFOWrite_packet),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A word is popped either from IDLE (then held one cycle in "primed" before
    // the link sees it) or on the handshake of the last byte so words run
    // back-to-back without a bubble.
    assign byte_done = tx_valid && tx_ready;
    assign last_byte = byte_done && (idx == LAST_BYTE_IDX);
    assign pop       = !fifo_empty && (((state == ST_IDLE) && !primed) || last_byte);

    assign hostPacketFIFOWrite_full = fifo_full;
    assign busy    = tx_valid || (fifo_count != '0);
    assign tx_data = tx_valid ? shreg[FIRST_BYTE_MSB -: 8] : 8'h00;

    // Serializer: load a word, then shift it left one byte per accepted beat.
    always_ff @(posedge clk100) begin
        if (!rst) begin
            state     <= ST_IDLE;
            primed    <= 1'b0;
            shreg     <= '0;
            idx       <= '0;
            tx_valid  <= 1'b0;
            wordsSent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (primed) begin
                        primed   <= 1'b0;
                        tx_valid <= 1'b1;
                        idx      <= '0;
                        state    <= ST_SEND;
                    end else if (pop) begin
                        shreg  <= fifo_dout;
                        primed <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (byte_done) begin
                        if (idx != LAST_BYTE_IDX) begin
                            idx   <= idx + 1'b1;
                            shreg <= {shreg[FIRST_BYTE_MSB-8:0], 8'h00};
                        end else begin
                            wordsSent <= wordsSent + 1'b1;
                            if (pop) begin
                                shreg <= fifo_dout;
                                idx   <= '0;
                            end else begin
                                tx_valid <= 1'b0;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    primed   <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of any write attempted while the FIFO was full.
    always_ff @(posedge clk100) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (hostPacketFIFOWriteEn && fifo_full) begin
            overflow <= 1'b1;
        end
    end

endmodule
